// File: rtl/regfile_write_arbiter.sv
// Two-requester write arbiter for the 32x64 register file write port.
// Optional read bypass of the output stage: define REGFILE_ARB_BYPASS_EN.
module regfile_write_arbiter #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Resetb,
    input  logic              AValid,
    output logic              AReady,
    input  logic [ADDR_W-1:0] ARw,
    input  logic [DATA_W-1:0] ABusW,
    input  logic              BValid,
    output logic              BReady,
    input  logic [ADDR_W-1:0] BRw,
    input  logic [DATA_W-1:0] BBusW,
    output logic [ADDR_W-1:0] RW,
    output logic [DATA_W-1:0] BusW,
    output logic              RegWr,
    input  logic [ADDR_W-1:0] RA,
    input  logic [ADDR_W-1:0] RB,
    output logic              RABusy,
    output logic              RBBusy,
    input  logic [DATA_W-1:0] BusAIn,
    input  logic [DATA_W-1:0] BusBIn,
    output logic [DATA_W-1:0] BusAOut,
    output logic [DATA_W-1:0] BusBOut
);

    localparam logic [ADDR_W-1:0] ZERO_REG = '1;
    localparam logic PTR_A = 1'b0;
    localparam logic PTR_B = 1'b1;

    logic              ha_v;
    logic [ADDR_W-1:0] ha_rw;
    logic [DATA_W-1:0] ha_data;
    logic              hb_v;
    logic [ADDR_W-1:0] hb_rw;
    logic [DATA_W-1:0] hb_data;
    logic              a_older;
    logic              ptr;

    logic grant_a;
    logic grant_b;
    logic a_take;
    logic b_take;
    logic same_rw;

    assign same_rw = (ha_rw == hb_rw);

    // Same-register conflicts follow age so writes to one register stay in order.
    always_comb begin
        grant_a = 1'b0;
        if (ha_v) begin
            if (!hb_v)
                grant_a = 1'b1;
            else if (same_rw)
                grant_a = a_older;
            else
                grant_a = (ptr == PTR_A);
        end
    end

    assign grant_b = hb_v && !grant_a;

    assign AReady = !ha_v || grant_a;
    assign BReady = !hb_v || grant_b;

    assign a_take = AValid && AReady && (ARw != ZERO_REG);
    assign b_take = BValid && BReady && (BRw != ZERO_REG);

    always_ff @(posedge Clk or negedge Resetb) begin
        if (!Resetb) begin
            ha_v    <= 1'b0;
            ha_rw   <= '0;
            ha_data <= '0;
            hb_v    <= 1'b0;
            hb_rw   <= '0;
            hb_data <= '0;
            a_older <= 1'b0;
            ptr     <= PTR_A;
            RegWr   <= 1'b0;
            RW      <= ZERO_REG;
            BusW    <= '0;
        end else begin
            if (a_take) begin
                ha_v    <= 1'b1;
                ha_rw   <= ARw;
                ha_data <= ABusW;
            end else if (grant_a) begin
                ha_v <= 1'b0;
            end

            if (b_take) begin
                hb_v    <= 1'b1;
                hb_rw   <= BRw;
                hb_data <= BBusW;
            end else if (grant_b) begin
                hb_v <= 1'b0;
            end

            if (a_take)
                a_older <= b_take;
            else if (b_take)
                a_older <= 1'b1;

            if (ha_v && hb_v)
                ptr <= grant_a ? PTR_B : PTR_A;

            RegWr <= grant_a || grant_b;
            if (grant_a) begin
                RW   <= ha_rw;
                BusW <= ha_data;
            end else if (grant_b) begin
                RW   <= hb_rw;
                BusW <= hb_data;
            end
        end
    end

    logic hold_a;
    logic hold_b;
    logic out_a;
    logic out_b;

    assign hold_a = (ha_v && ha_rw == RA) || (hb_v && hb_rw == RA);
    assign hold_b = (ha_v && ha_rw == RB) || (hb_v && hb_rw == RB);
    assign out_a  = RegWr && (RW == RA);
    assign out_b  = RegWr && (RW == RB);

`ifdef REGFILE_ARB_BYPASS_EN
    assign RABusy  = (RA != ZERO_REG) && hold_a;
    assign RBBusy  = (RB != ZERO_REG) && hold_b;
    assign BusAOut = (out_a && RA != ZERO_REG) ? BusW : BusAIn;
    assign BusBOut = (out_b && RB != ZERO_REG) ? BusW : BusBIn;
`else
    assign RABusy  = (RA != ZERO_REG) && (hold_a || out_a);
    assign RBBusy  = (RB != ZERO_REG) && (hold_b || out_b);
    assign BusAOut = BusAIn;
    assign BusBOut = BusBIn;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register file.
// Cycle n spans posedge n to posedge n+1; checks happen before the falling edge.
module tb_regfile_write_arbiter;

`ifdef REGFILE_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        Clk;
    logic        Resetb;
    logic        AValid, AReady, BValid, BReady;
    logic [4:0]  ARw, BRw, RW, RA, RB;
    logic [63:0] ABusW, BBusW, BusW;
    logic        RegWr, RABusy, RBBusy;
    logic [63:0] BusAIn, BusBIn, BusAOut, BusBOut;

    logic [63:0] rf [32];
    int checks = 0;
    int errors = 0;

    regfile_write_arbiter dut (
        .Clk(Clk), .Resetb(Resetb),
        .AValid(AValid), .AReady(AReady), .ARw(ARw), .ABusW(ABusW),
        .BValid(BValid), .BReady(BReady), .BRw(BRw), .BBusW(BBusW),
        .RW(RW), .BusW(BusW), .RegWr(RegWr),
        .RA(RA), .RB(RB), .RABusy(RABusy), .RBBusy(RBBusy),
        .BusAIn(BusAIn), .BusBIn(BusBIn),
        .BusAOut(BusAOut), .BusBOut(BusBOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(negedge Clk)
        if (Resetb && RegWr && RW != 5'd31)
            rf[RW] <= BusW;

    assign BusAIn = rf[RA];
    assign BusBIn = rf[RB];

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        AValid = 1'b0; BValid = 1'b0;
        ARw = 5'd0; BRw = 5'd0;
        ABusW = '0; BBusW = '0;
    endtask

    task automatic do_reset();
        idle();
        Resetb = 1'b0;
        next_cycle();
        next_cycle();
        Resetb = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) rf[i] = '0;
        RA = 5'd0; RB = 5'd0;
        do_reset();
        #3;
        checks++;
        if (RegWr !== 1'b0 || RW !== 5'd31 || BusW !== 64'h0) begin
            errors++;
            $display("FAIL reset_out: RegWr=%b RW=%0d BusW=%h want 0/31/0",
                     RegWr, RW, BusW);
        end
        checks++;
        if (AReady !== 1'b1 || BReady !== 1'b1 || RABusy !== 1'b0 || RBBusy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: AR=%b BR=%b RAB=%b RBB=%b want 1100",
                     AReady, BReady, RABusy, RBBusy);
        end
    endtask

    task automatic test_single();
        next_cycle();
        RA = 5'd5;
        AValid = 1'b1; ARw = 5'd5; ABusW = 64'h12345678;
        #3;
        checks++;
        if (AReady !== 1'b1 || RABusy !== 1'b0) begin
            errors++;
            $display("FAIL single_c0: AReady=%b RABusy=%b want 1 0", AReady, RABusy);
        end
        next_cycle();
        idle();
        #3;
        checks++;
        if (RegWr !== 1'b0 || RABusy !== 1'b1) begin
            errors++;
            $display("FAIL single_c1: RegWr=%b RABusy=%b want 0 1", RegWr, RABusy);
        end
        next_cycle();
        #3;
        checks++;
        if (RegWr !== 1'b1 || RW !== 5'd5 || BusW !== 64'h12345678) begin
            errors++;
            $display("FAIL single_c2: RegWr=%b RW=%0d BusW=%h want 1 5 12345678",
                     RegWr, RW, BusW);
        end
        checks++;
        if (RABusy !== !BYP) begin
            errors++;
            $display("FAIL single_c2_busy: RABusy=%b want %b", RABusy, !BYP);
        end
        next_cycle();
        #3;
        checks++;
        if (RegWr !== 1'b0 || RABusy !== 1'b0 || BusAOut !== 64'h12345678) begin
            errors++;
            $display("FAIL single_c3: RegWr=%b RABusy=%b BusAOut=%h want 0 0 12345678",
                     RegWr, RABusy, BusAOut);
        end
    endtask

    task automatic test_contention();
        logic [4:0]  a_rw [2];
        logic [4:0]  b_rw [2];
        logic [4:0]  first_rw [2];
        logic [4:0]  second_rw [2];
        a_rw[0] = 5'd1; b_rw[0] = 5'd2; first_rw[0] = 5'd1; second_rw[0] = 5'd2;
        a_rw[1] = 5'd3; b_rw[1] = 5'd4; first_rw[1] = 5'd4; second_rw[1] = 5'd3;
        for (int r = 0; r < 2; r++) begin
            next_cycle();
            AValid = 1'b1; ARw = a_rw[r]; ABusW = 64'(a_rw[r]);
            BValid = 1'b1; BRw = b_rw[r]; BBusW = 64'(b_rw[r]);
            next_cycle();
            idle();
            #3;
            checks++;
            if (RegWr !== 1'b0 || (AReady ^ BReady) !== 1'b1) begin
                errors++;
                $display("FAIL cont%0d_c1: RegWr=%b AR=%b BR=%b want 0 and one ready",
                         r, RegWr, AReady, BReady);
            end
            next_cycle();
            #3;
            checks++;
            if (RegWr !== 1'b1 || RW !== first_rw[r] || BusW !== 64'(first_rw[r])) begin
                errors++;
                $display("FAIL cont%0d_first: RegWr=%b RW=%0d BusW=%h want 1 %0d",
                         r, RegWr, RW, BusW, first_rw[r]);
            end
            next_cycle();
            #3;
            checks++;
            if (RegWr !== 1'b1 || RW !== second_rw[r] || BusW !== 64'(second_rw[r])) begin
                errors++;
                $display("FAIL cont%0d_second: RegWr=%b RW=%0d BusW=%h want 1 %0d",
                         r, RegWr, RW, BusW, second_rw[r]);
            end
        end
    endtask

    task automatic test_ordering();
        do_reset();
        RA = 5'd7;
        BValid = 1'b1; BRw = 5'd7; BBusW = 64'hB;
        next_cycle();
        idle();
        AValid = 1'b1; ARw = 5'd7; ABusW = 64'hA;
        next_cycle();
        idle();
        #3;
        checks++;
        if (RegWr !== 1'b1 || RW !== 5'd7 || BusW !== 64'hB) begin
            errors++;
            $display("FAIL order_first: RegWr=%b RW=%0d BusW=%h want 1 7 b",
                     RegWr, RW, BusW);
        end
        next_cycle();
        #3;
        checks++;
        if (RegWr !== 1'b1 || RW !== 5'd7 || BusW !== 64'hA) begin
            errors++;
            $display("FAIL order_second: RegWr=%b RW=%0d BusW=%h want 1 7 a",
                     RegWr, RW, BusW);
        end
        next_cycle();
        #3;
        checks++;
        if (BusAOut !== 64'hA || RABusy !== 1'b0) begin
            errors++;
            $display("FAIL order_final: BusAOut=%h RABusy=%b want a 0", BusAOut, RABusy);
        end
    endtask

    task automatic test_zero_reg();
        next_cycle();
        RA = 5'd31;
        AValid = 1'b1; ARw = 5'd31; ABusW = 64'hFFFF;
        #3;
        checks++;
        if (AReady !== 1'b1) begin
            errors++;
            $display("FAIL zero_ready: AReady=%b want 1", AReady);
        end
        for (int c = 1; c < 4; c++) begin
            next_cycle();
            idle();
            #3;
            checks++;
            if (RegWr !== 1'b0 || RABusy !== 1'b0 || BusAOut !== 64'h0) begin
                errors++;
                $display("FAIL zero_c%0d: RegWr=%b RABusy=%b BusAOut=%h want 0 0 0",
                         c, RegWr, RABusy, BusAOut);
            end
        end
    endtask

    task automatic test_bypass();
        next_cycle();
        RA = 5'd9;
        AValid = 1'b1; ARw = 5'd9; ABusW = 64'h55;
        next_cycle();
        idle();
        next_cycle();
        #3;
        checks++;
        if (RABusy !== !BYP || BusAOut !== (BYP ? 64'h55 : 64'h0)) begin
            errors++;
            $display("FAIL bypass_c2: RABusy=%b BusAOut=%h want %b %h",
                     RABusy, BusAOut, !BYP, BYP ? 64'h55 : 64'h0);
        end
    endtask

    task automatic test_back_to_back();
        next_cycle();
        for (int c = 0; c < 6; c++) begin
            if (c < 4) begin
                AValid = 1'b1; ARw = 5'(12 + c); ABusW = 64'(16'hC0 + c);
            end else begin
                idle();
            end
            #3;
            checks++;
            if (AReady !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_c%0d: AReady=%b want 1", c, AReady);
            end
            if (c >= 2) begin
                checks++;
                if (RegWr !== 1'b1 || RW !== 5'(10 + c) || BusW !== 64'(16'hC0 + c - 2)) begin
                    errors++;
                    $display("FAIL b2b_c%0d: RegWr=%b RW=%0d BusW=%h want 1 %0d %h",
                             c, RegWr, RW, BusW, 10 + c, 16'hC0 + c - 2);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid();
        RA = 5'd10; RB = 5'd11;
        AValid = 1'b1; ARw = 5'd10; ABusW = 64'hAA;
        BValid = 1'b1; BRw = 5'd11; BBusW = 64'hBB;
        next_cycle();
        AValid = 1'b1; ARw = 5'd10; ABusW = 64'hAB;
        BValid = 1'b1; BRw = 5'd11; BBusW = 64'hBC;
        next_cycle();
        idle();
        #2;
        checks++;
        if (RegWr !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_pre: RegWr=%b want 1", RegWr);
        end
        Resetb = 1'b0;
        #1;
        checks++;
        if (RegWr !== 1'b0 || RW !== 5'd31 || BusW !== 64'h0 ||
            AReady !== 1'b1 || BReady !== 1'b1 || RABusy !== 1'b0 || RBBusy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid: RegWr=%b RW=%0d BusW=%h AR=%b BR=%b RAB=%b RBB=%b",
                     RegWr, RW, BusW, AReady, BReady, RABusy, RBBusy);
        end
        next_cycle();
        Resetb = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            #3;
            checks++;
            if (RegWr !== 1'b0 || BusAOut !== 64'h0 || BusBOut !== 64'h0) begin
                errors++;
                $display("FAIL rstmid_after%0d: RegWr=%b BusAOut=%h BusBOut=%h want 0 0 0",
                         c, RegWr, BusAOut, BusBOut);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_ordering();
        test_zero_reg();
        test_bypass();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

- Shares the single write port (RW/BusW/RegWr) of the 32×64 RegisterFile between two writeback requesters, A and B.
- Each requester gets a one-entry holding buffer with a valid/ready handshake.
- Arbitration is round-robin but age-ordered for same-register conflicts, and the output stage is registered.
- Also reports per-read-port hazards (pending writes to RA/RB) so the decode/stall logic can hold readers; X31 (zero register) writes are absorbed without using the port.

## Interface
- DATA_W, 64, write data width (matches BusW)
- ADDR_W, 5, register index width; register 31 is the hard-zero register
- Clk  in  1  system clock; all state updates on rising edge
- Resetb  in  1  asynchronous, active-low reset
- AValid  in  1  requester A write request
- AReady  out  1  buffer A can accept this cycle
- ARw  in  ADDR_W  requester A destination register
- ABusW  in  DATA_W  requester A write data
- BValid, BReady, BRw, BBusW  —  identical set for requester B
- RW  out  ADDR_W  to RegisterFile write address
- BusW  out  DATA_W  to RegisterFile write data
- RegWr  out  1  to RegisterFile write enable
- RA, RB  in  ADDR_W  current read addresses presented to RegisterFile
- RABusy, RBBusy  out  1  a pending (uncommitted) write targets RA / RB
- BusAIn, BusBIn  in  DATA_W  RegisterFile BusA/BusB
- BusAOut, BusBOut  out  DATA_W  read data to datapath (see Configuration)

## Operation
- Holding buffers HA, HB: {valid, rw, data, seq}.
- XReady = !HX.valid || grantX. grantX depends only on holding-buffer state, so there is no combinational path from XValid to XReady.
- Handshake: a transfer occurs when XValid && XReady at a rising edge.
  - Rw≠31: entry captured into HX.
  - Rw==31: transfer acknowledged and discarded; HX is unchanged.
- Age: each capture records seq. `AOlder` flag is set/cleared on capture. If both are captured on the same edge, A is older.
- Grant rules, evaluated each cycle from HA/HB:
  - Only one valid: grant it.
  - Both valid, same rw: grant the older.
  - Both valid, different rw: grant the side named by the round-robin pointer `Ptr`. Reset value is A. After any grant while both are valid, Ptr moves to the other side.
- On grant, the winner is loaded into the output stage at the next edge: RW=rw, BusW=data, RegWr=1. The winner's buffer frees on that edge, or refills if a new transfer occurs.
- No grant: RegWr=0 at the next edge. RW and BusW hold their previous values.
- RegisterFile commits during the RegWr=1 cycle on its falling edge. The output stage is therefore treated as committed at the end of that cycle.
- RABusy = RA≠31 && (match HA or HB or output stage with RegWr=1). RBBusy is the same for RB.

## Timing
- Latency: request presented in cycle 0 → captured at end of cycle 0 → granted in cycle 1 → RegWr=1 in cycle 2 → readable from RegisterFile from cycle 3 onward.
- Throughput: one write per cycle total. A sole active requester sustains one per cycle. Under contention each side gets one per two cycles.
- Reset values (Resetb low, asynchronous):
  - RegWr=0, RW=31, BusW=0
  - HA/HB invalid, Ptr=A, AOlder=0
  - AReady=BReady=1, RABusy=RBBusy=0
- Reset mid-operation: all pending writes are lost and RegWr drops immediately. No partial write is issued after Resetb deasserts.
- Both buffers full and no new input: grants alternate as above. No entry waits more than 2 cycles after becoming eligible.

## Configuration
- REGFILE_ARB_BYPASS_EN defined:
  - BusAOut = BusW when RegWr && RW==RA && RA≠31, else BusAIn. BusBOut is the same for RB.
  - The output-stage match is excluded from RABusy/RBBusy; only holding-buffer matches assert busy.
- Undefined: BusAOut=BusAIn and BusBOut=BusBIn (pure pass-through); busy includes the output stage.

## Test plan
- Reset: Resetb=0 mid-traffic with RegWr=1 → same cycle RegWr=0, RW=31, BusW=0, AReady=BReady=1, busy flags 0.
- Single write: A writes X5=64'h12345678 in cycle 0 → cycle 2 RegWr=1, RW=5, BusW=64'h12345678. RA=5 reads 64'h12345678 from cycle 3. RABusy=1 in cycles 1–2 (cycle 1 only with bypass).
- Contention: A (X1=1) and B (X2=2) in the same cycle → X1 written cycle 2, X2 cycle 3. Repeat with X3/X4 → B's X4 goes first (Ptr toggled).
- Ordering: B writes X7=64'hB in cycle 0, A writes X7=64'hA in cycle 1 with Ptr=A → X7=0xB commits before 0xA; final read of X7 = 64'hA.
- Zero register: A writes X31=64'hFFFF with AValid=1 → AReady=1, RegWr stays 0, RA=31 gives RABusy=0 and BusAOut=0.
- Bypass (macro on): A writes X9=64'h55 and RA=9 is held → in cycle 2 BusAOut=64'h55 while RABusy=0. With the macro off, cycle 2 has RABusy=1 and BusAOut=BusAIn.
